// File: rtl/hazard_pkg.sv
// hazard_pkg: opcode constants, the per-instruction register-usage record and
// the decode helper shared by the ID-stage scoreboard and the forwarding unit.
// Reads the HAZARD_FORWARDING_EN macro only indirectly (see hazard_scoreboard).
package hazard_pkg;

  localparam int REGW = 5;  // MIPS register specifier width

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;

  // Which source fields an instruction reads, and which register it writes.
  typedef struct packed {
    logic            rs_rd_en;
    logic            rt_rd_en;
    logic            wr_en;
    logic [REGW-1:0] wr_reg;
    logic            is_load;
  } decode_t;

  // An all-zero word is a NOP: it reads and writes nothing.
  function automatic decode_t decode_instr(input logic [31:0] instr);
    decode_t d;
    d = '0;
    if (instr != 32'b0) begin
      case (instr[31:26])
        OP_RTYPE: begin
          d.rs_rd_en = 1'b1;
          d.rt_rd_en = 1'b1;
          d.wr_en    = 1'b1;
          d.wr_reg   = instr[15:11];
        end
        OP_LW: begin
          d.rs_rd_en = 1'b1;
          d.wr_en    = 1'b1;
          d.wr_reg   = instr[20:16];
          d.is_load  = 1'b1;
        end
        OP_SW, OP_BEQ, OP_BNE: begin
          d.rs_rd_en = 1'b1;
          d.rt_rd_en = 1'b1;
        end
        OP_J: begin
          // jumps touch no general-purpose register
        end
        default: begin
          // remaining I-type: reads rs, writes rt
          d.rs_rd_en = 1'b1;
          d.wr_en    = 1'b1;
          d.wr_reg   = instr[20:16];
        end
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/hazard_decode.sv
// hazard_decode: purely combinational opcode-to-register-usage decode.
// Also extracts the rs/rt specifiers so hazard logic never slices the word.
module hazard_decode
  import hazard_pkg::*;
(
  input  logic [31:0]     i_instr,
  output decode_t         o_dec,
  output logic [REGW-1:0] o_rs,
  output logic [REGW-1:0] o_rt
);

  assign o_dec = decode_instr(i_instr);
  assign o_rs  = i_instr[25:21];
  assign o_rt  = i_instr[20:16];

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: ID-stage data-stall unit built on a per-register
// countdown scoreboard. A writer loads its destination's counter on issue;
// any reader of a register with a nonzero counter stalls IF/ID while the
// ID/EX latch receives bubbles. Stall cycles are counted (saturating).
// Macro HAZARD_FORWARDING_EN: when defined, EX/MEM forwarding is assumed and
// only load destinations are tracked (LOAD_STALL); otherwise every writer
// loads RAW_STALL.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int NREG       = 32,
  parameter int RAW_STALL  = 2,
  parameter int LOAD_STALL = 1,
  parameter int CNTW       = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] id_instr,
  input  logic            id_flush,
  output logic            stall,
  output logic [XLEN-1:0] ex_instr,
  output logic [CNTW-1:0] stall_cycles,
  output logic [NREG-1:0] busy_mask
);

  localparam int MAX_STALL = (RAW_STALL > LOAD_STALL) ? RAW_STALL : LOAD_STALL;
  localparam int SBW       = $clog2(MAX_STALL + 1);

  // Register 0 is never tracked, so the counter array starts at index 1.
  logic [SBW-1:0]  r_cnt [1:NREG-1];
  logic [XLEN-1:0] r_ex_instr;
  logic [CNTW-1:0] r_stall_cycles;

  decode_t         w_dec;
  logic [REGW-1:0] w_rs;
  logic [REGW-1:0] w_rt;
  logic [NREG-1:0] w_busy;
  logic            w_stall;
  logic            w_issue;
  logic            w_load_en;
  logic            w_load;
  logic [SBW-1:0]  w_load_val;

  hazard_decode u_decode (
    .i_instr (id_instr[31:0]),
    .o_dec   (w_dec),
    .o_rs    (w_rs),
    .o_rt    (w_rt)
  );

`ifdef HAZARD_FORWARDING_EN
  // Forwarding covers ALU results; only a load's data arrives too late.
  assign w_load_en  = w_dec.wr_en & w_dec.is_load;
  assign w_load_val = SBW'(LOAD_STALL);
`else
  logic w_unused_is_load;
  assign w_unused_is_load = w_dec.is_load;
  assign w_load_en  = w_dec.wr_en;
  assign w_load_val = SBW'(RAW_STALL);
`endif

  // Busy vector from the counters; bit 0 stays clear so $0 never stalls.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
    w_busy = '0;
    for (int i = 1; i < NREG; i++) begin
      w_busy[i] = (r_cnt[i] != '0);
    end
  end

  assign w_stall = ((w_dec.rs_rd_en & w_busy[w_rs]) |
                    (w_dec.rt_rd_en & w_busy[w_rt])) & ~id_flush;
  assign w_issue = (id_instr != '0) & ~w_stall & ~id_flush;
  assign w_load  = w_issue & w_load_en & (w_dec.wr_reg != '0);

  // Countdown scoreboard: load on issue, otherwise decrement toward zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: this array is architectural hazard state (flops, not a RAM), so every entry is cleared on reset.
      for (int i = 1; i < NREG; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 1; i < NREG; i++) begin
        // NOTE: sequential state uses non-blocking assignments so every counter samples pre-edge values.
        if (w_load && (w_dec.wr_reg == REGW'(i))) begin
          r_cnt[i] <= w_load_val;
        end else if (r_cnt[i] != '0) begin
          r_cnt[i] <= r_cnt[i] - SBW'(1);
        end
      end
    end
  end

  // ID/EX instruction latch: pass the issued instruction, else a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ex_instr <= '0;
    end else begin
      r_ex_instr <= w_issue ? id_instr : '0;
    end
  end

  // Saturating count of stalled cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cycles <= '0;
    end else if (w_stall && (r_stall_cycles != '1)) begin
      r_stall_cycles <= r_stall_cycles + CNTW'(1);
    end
  end

  assign stall        = w_stall;
  assign ex_instr     = r_ex_instr;
  assign stall_cycles = r_stall_cycles;
  assign busy_mask    = w_busy;

endmodule
